// File: rtl/hazard_scoreboard_if.sv
// Decode/EX control bus between the pipeline datapath and hazard_scoreboard.
// master = datapath side (drives decode fields, consumes stall/flush/forward),
// slave  = hazard_scoreboard.
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int FW     = 2,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_regwrite;
   logic              id_is_load;
   logic              ex_redirect;
   logic              stall_f;
   logic              stall_d;
   logic              flush_d;
   logic              flush_e;
   logic [FW-1:0]     fwd_a_sel;
   logic [FW-1:0]     fwd_b_sel;
   logic [CNT_W-1:0]  stat_stall_cnt;
   logic [CNT_W-1:0]  stat_flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_regwrite, id_is_load, ex_redirect,
      input  stall_f, stall_d, flush_d, flush_e,
             fwd_a_sel, fwd_b_sel, stat_stall_cnt, stat_flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_regwrite, id_is_load, ex_redirect,
      output stall_f, stall_d, flush_d, flush_e,
             fwd_a_sel, fwd_b_sel, stat_stall_cnt, stat_flush_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow pipeline of in-flight destinations (EX..WB) that
// produces load-use stalls, redirect flushes and EX forwarding selects.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the statistics ports are tied to zero.
module hazard_scoreboard #(
   parameter int NSTAGE     = 3,
   parameter int LOAD_READY = 2,
   parameter int REG_AW     = 5,
   parameter int FW         = $clog2(NSTAGE),
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave hz
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regWrite;
      logic              isLoad;
   } entry_t;

   // stage[0] = EX ... stage[NSTAGE-1] = WB
   entry_t [NSTAGE-1:0] stage;
   logic [REG_AW-1:0]   exRs1;
   logic [REG_AW-1:0]   exRs2;
   logic                exUseRs1;
   logic                exUseRs2;
   logic                loadStall;
   logic                stallD;
   logic                advance;

   // x0 is hard-wired zero, so it never depends on an in-flight producer.
   function automatic logic srcMatch(input logic useBit, input logic [REG_AW-1:0] src,
                                     input entry_t e);
      return useBit && e.valid && e.regWrite && (e.rd == src) && (src != '0);
   endfunction

   // Scan oldest to youngest so the youngest forwardable producer wins.
   function automatic logic [FW-1:0] fwdSelect(input logic useBit, input logic [REG_AW-1:0] src,
                                               input entry_t [NSTAGE-1:0] st);
      logic [FW-1:0] sel;
      sel = '0;
      for (int k = NSTAGE - 1; k >= 1; k--) begin
         if (srcMatch(useBit, src, st[k]) && (!st[k].isLoad || k >= LOAD_READY))
            sel = FW'(k);
      end
      return sel;
   endfunction

   // Load-use detection: a decode source waits on a load whose data is not
   // yet forwardable by the time the consumer would reach EX.
   always_comb begin
      loadStall = 1'b0;
      for (int k = 0; k < NSTAGE - 1; k++) begin
         if (hz.id_valid && (k + 1 < LOAD_READY) && stage[k].isLoad &&
             (srcMatch(hz.id_use_rs1, hz.id_rs1, stage[k]) ||
              srcMatch(hz.id_use_rs2, hz.id_rs2, stage[k])))
            loadStall = 1'b1;
      end
   end

   // A redirect kills the D instruction, so it overrides any load-use stall.
   assign stallD     = loadStall && !hz.ex_redirect;
   assign advance    = hz.id_valid && !loadStall && !hz.ex_redirect;

   assign hz.stall_f   = !reset && stallD;
   assign hz.stall_d   = !reset && stallD;
   assign hz.flush_d   = !reset && hz.ex_redirect;
   assign hz.flush_e   = !reset && (hz.ex_redirect || loadStall);
   assign hz.fwd_a_sel = reset ? '0 : fwdSelect(exUseRs1, exRs1, stage);
   assign hz.fwd_b_sel = reset ? '0 : fwdSelect(exUseRs2, exRs2, stage);

   // Shadow pipeline shift; a bubble enters EX on stall, redirect or empty D.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage    <= '0;
         exRs1    <= '0;
         exRs2    <= '0;
         exUseRs1 <= 1'b0;
         exUseRs2 <= 1'b0;
      end else begin
         for (int k = 1; k < NSTAGE; k++)
            stage[k] <= stage[k-1];
         if (advance) begin
            stage[0] <= '{valid: 1'b1, rd: hz.id_rd, regWrite: hz.id_regwrite,
                          isLoad: hz.id_is_load};
            exRs1    <= hz.id_rs1;
            exRs2    <= hz.id_rs2;
            exUseRs1 <= hz.id_use_rs1;
            exUseRs2 <= hz.id_use_rs2;
         end else begin
            stage[0] <= '0;
            exRs1    <= '0;
            exRs2    <= '0;
            exUseRs1 <= 1'b0;
            exUseRs2 <= 1'b0;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   // Saturating event counters: stall cycles and redirect cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stallD)
            stallCnt <= satInc(stallCnt);
         if (hz.ex_redirect)
            flushCnt <= satInc(flushCnt);
      end
   end

   assign hz.stat_stall_cnt = reset ? '0 : stallCnt;
   assign hz.stat_flush_cnt = reset ? '0 : flushCnt;
`else
   assign hz.stat_stall_cnt = '0;
   assign hz.stat_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default-parameter instance
// (NSTAGE=3, LOAD_READY=2) and a deeper one (NSTAGE=5, LOAD_READY=3).
// Expected responses are queued when each step is driven and checked
// against the DUT at the following falling edge.
module tb_hazard_scoreboard;
   localparam int REG_AW = 5;
   localparam int CNT_W  = 16;
   localparam int N0 = 3, LR0 = 2, FW0 = $clog2(N0);
   localparam int N1 = 5, LR1 = 3, FW1 = $clog2(N1);
`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam logic [3:0] NO    = 4'b0000;  // {stall_f, stall_d, flush_d, flush_e}
   localparam logic [3:0] STALL = 4'b1101;
   localparam logic [3:0] REDIR = 4'b0011;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
   } instr_t;

   typedef struct packed {
      logic [3:0]  ctl;
      logic [3:0]  fwdA;
      logic [3:0]  fwdB;
      logic [15:0] cntS;
      logic [15:0] cntF;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nAssert = 0;
   int   nFail   = 0;
   int   mStall[2];
   int   mFlush[2];
   exp_t  expQ[$];
   string tagQ[$];

   instr_t NOP, ADD5, SUB6, OR7, X0W, RD0, LW8, ADD9, A3, LD3, U3, U9;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_AW(REG_AW), .FW(FW0), .CNT_W(CNT_W)) hz0 ();
   hazard_scoreboard_if #(.REG_AW(REG_AW), .FW(FW1), .CNT_W(CNT_W)) hz1 ();

   hazard_scoreboard #(.NSTAGE(N0), .LOAD_READY(LR0), .REG_AW(REG_AW), .FW(FW0), .CNT_W(CNT_W))
      dut0 (.clk(clk), .reset(rst), .hz(hz0.slave));
   hazard_scoreboard #(.NSTAGE(N1), .LOAD_READY(LR1), .REG_AW(REG_AW), .FW(FW1), .CNT_W(CNT_W))
      dut1 (.clk(clk), .reset(rst), .hz(hz1.slave));

   function automatic instr_t mk(input int rd, input bit rw, input bit ld,
                                 input int rs1, input bit u1, input int rs2, input bit u2);
      instr_t i;
      i.valid = 1'b1;
      i.rd = 5'(rd); i.rw = rw; i.ld = ld;
      i.rs1 = 5'(rs1); i.u1 = u1;
      i.rs2 = 5'(rs2); i.u2 = u2;
      return i;
   endfunction

   task automatic drive(input int d, input instr_t i, input logic redir);
      instr_t a, b;
      a = (d == 0) ? i : '0;
      b = (d == 1) ? i : '0;
      hz0.id_valid = a.valid; hz0.id_rs1 = a.rs1; hz0.id_use_rs1 = a.u1;
      hz0.id_rs2 = a.rs2; hz0.id_use_rs2 = a.u2; hz0.id_rd = a.rd;
      hz0.id_regwrite = a.rw; hz0.id_is_load = a.ld; hz0.ex_redirect = (d == 0) && redir;
      hz1.id_valid = b.valid; hz1.id_rs1 = b.rs1; hz1.id_use_rs1 = b.u1;
      hz1.id_rs2 = b.rs2; hz1.id_use_rs2 = b.u2; hz1.id_rd = b.rd;
      hz1.id_regwrite = b.rw; hz1.id_is_load = b.ld; hz1.ex_redirect = (d == 1) && redir;
   endtask

   function automatic exp_t sample(input int d);
      exp_t o;
      if (d == 0) begin
         o.ctl  = {hz0.stall_f, hz0.stall_d, hz0.flush_d, hz0.flush_e};
         o.fwdA = 4'(hz0.fwd_a_sel);
         o.fwdB = 4'(hz0.fwd_b_sel);
         o.cntS = hz0.stat_stall_cnt;
         o.cntF = hz0.stat_flush_cnt;
      end else begin
         o.ctl  = {hz1.stall_f, hz1.stall_d, hz1.flush_d, hz1.flush_e};
         o.fwdA = 4'(hz1.fwd_a_sel);
         o.fwdB = 4'(hz1.fwd_b_sel);
         o.cntS = hz1.stat_stall_cnt;
         o.cntF = hz1.stat_flush_cnt;
      end
      return o;
   endfunction

   task automatic cmp(input string tag, input string field, input logic [15:0] obs,
                      input logic [15:0] expv);
      nAssert++;
      assert (obs === expv) else begin
         nFail++;
         $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
      end
   endtask

   task automatic step(input int d, input logic r, input instr_t i, input logic redir,
                       input logic [3:0] ctl, input logic [3:0] fa, input logic [3:0] fb,
                       input string tag);
      exp_t  e, o;
      string t;
      @(posedge clk);
      #1;
      rst = r;
      drive(d, i, redir);
      e.ctl  = ctl;
      e.fwdA = fa;
      e.fwdB = fb;
      e.cntS = (STATS && !r) ? 16'(mStall[d]) : 16'd0;
      e.cntF = (STATS && !r) ? 16'(mFlush[d]) : 16'd0;
      expQ.push_back(e);
      tagQ.push_back(tag);
      if (r) begin
         mStall[0] = 0; mStall[1] = 0; mFlush[0] = 0; mFlush[1] = 0;
      end else begin
         if (ctl[2]) mStall[d]++;
         if (redir)  mFlush[d]++;
      end
      @(negedge clk);
      e = expQ.pop_front();
      t = tagQ.pop_front();
      o = sample(d);
      cmp(t, "stall_f", 16'(o.ctl[3]), 16'(e.ctl[3]));
      cmp(t, "stall_d", 16'(o.ctl[2]), 16'(e.ctl[2]));
      cmp(t, "flush_d", 16'(o.ctl[1]), 16'(e.ctl[1]));
      cmp(t, "flush_e", 16'(o.ctl[0]), 16'(e.ctl[0]));
      cmp(t, "fwd_a",   16'(o.fwdA),   16'(e.fwdA));
      cmp(t, "fwd_b",   16'(o.fwdB),   16'(e.fwdB));
      cmp(t, "stat_stall", o.cntS, e.cntS);
      cmp(t, "stat_flush", o.cntF, e.cntF);
   endtask

   initial begin
      mStall[0] = 0; mStall[1] = 0; mFlush[0] = 0; mFlush[1] = 0;
      NOP  = '0;
      ADD5 = mk(5, 1, 0, 1, 1, 2, 1);
      SUB6 = mk(6, 1, 0, 5, 1, 1, 1);
      OR7  = mk(7, 1, 0, 5, 1, 0, 1);
      X0W  = mk(0, 1, 0, 0, 0, 0, 0);
      RD0  = mk(11, 1, 0, 0, 1, 0, 1);
      LW8  = mk(8, 1, 1, 1, 1, 0, 0);
      ADD9 = mk(9, 1, 0, 8, 1, 8, 1);
      A3   = mk(3, 1, 0, 0, 0, 0, 0);
      LD3  = mk(3, 1, 1, 0, 0, 0, 0);
      U3   = mk(12, 1, 0, 3, 1, 0, 0);
      U9   = mk(13, 1, 0, 9, 1, 0, 0);
      drive(0, NOP, 1'b0);

      // reset: outputs held low even with hazardous inputs
      step(0, 1, ADD9, 1, NO, 0, 0, "rst_a");
      step(0, 1, LW8,  0, NO, 0, 0, "rst_b");

      // back-to-back ALU hazards and x0
      step(0, 0, ADD5, 0, NO, 0, 0, "alu_add");
      step(0, 0, SUB6, 0, NO, 0, 0, "alu_sub_d");
      step(0, 0, OR7,  0, NO, 1, 0, "alu_fwd1");
      step(0, 0, X0W,  0, NO, 2, 0, "alu_fwd2_x0");
      step(0, 0, RD0,  0, NO, 0, 0, "x0_d");
      step(0, 0, NOP,  0, NO, 0, 0, "x0_never_fwd");
      step(0, 0, NOP,  0, NO, 0, 0, "drain_a");
      step(0, 0, NOP,  0, NO, 0, 0, "drain_b");

      // load-use with defaults: one stall cycle, then forward from stage 2
      step(0, 0, LW8,  0, NO,    0, 0, "lu_load");
      step(0, 0, ADD9, 0, STALL, 0, 0, "lu_stall");
      step(0, 0, ADD9, 0, NO,    0, 0, "lu_release");
      step(0, 0, NOP,  0, NO,    2, 2, "lu_fwd2");
      step(0, 0, NOP,  0, NO,    0, 0, "lu_drain_a");
      step(0, 0, NOP,  0, NO,    0, 0, "lu_drain_b");

      // priority: youngest producer wins
      step(0, 0, A3,  0, NO, 0, 0, "pri_a3");
      step(0, 0, A3,  0, NO, 0, 0, "pri_b3");
      step(0, 0, U3,  0, NO, 0, 0, "pri_use_d");
      step(0, 0, NOP, 0, NO, 1, 0, "pri_fwd1");
      step(0, 0, NOP, 0, NO, 0, 0, "pri_drain_a");
      step(0, 0, NOP, 0, NO, 0, 0, "pri_drain_b");

      // priority with a load as the younger producer
      step(0, 0, A3,  0, NO,    0, 0, "pld_a3");
      step(0, 0, LD3, 0, NO,    0, 0, "pld_ld3");
      step(0, 0, U3,  0, STALL, 0, 0, "pld_stall");
      step(0, 0, U3,  0, NO,    0, 0, "pld_release");
      step(0, 0, NOP, 0, NO,    2, 0, "pld_fwd2");
      step(0, 0, NOP, 0, NO,    0, 0, "pld_drain_a");
      step(0, 0, NOP, 0, NO,    0, 0, "pld_drain_b");

      // redirect in the same cycle as a load-use
      step(0, 0, LW8,  0, NO,    0, 0, "rd_load");
      step(0, 0, ADD9, 1, REDIR, 0, 0, "rd_override");
      step(0, 0, U9,   0, NO,    0, 0, "rd_after");
      step(0, 0, NOP,  0, NO,    0, 0, "rd_bubble");
      step(0, 0, NOP,  0, NO,    0, 0, "rd_drain_a");
      step(0, 0, NOP,  0, NO,    0, 0, "rd_drain_b");

      // deep instance: reset while a load-use is pending
      step(1, 0, LW8,  0, NO, 0, 0, "d1_load");
      step(1, 1, ADD9, 0, NO, 0, 0, "d1_rst_stall");
      step(1, 0, ADD9, 0, NO, 0, 0, "d1_post_rst");

      // deep instance: load-use at distance 1 stalls two cycles
      step(1, 0, LW8,  0, NO,    0, 0, "d1_lu_load");
      step(1, 0, ADD9, 0, STALL, 0, 0, "d1_lu_stall1");
      step(1, 0, ADD9, 0, STALL, 0, 0, "d1_lu_stall2");
      step(1, 0, ADD9, 0, NO,    0, 0, "d1_lu_release");
      step(1, 0, NOP,  0, NO,    3, 3, "d1_lu_fwd3");

      // deep instance: three redirects
      step(1, 0, NOP, 1, REDIR, 0, 0, "d1_redir1");
      step(1, 0, NOP, 1, REDIR, 0, 0, "d1_redir2");
      step(1, 0, NOP, 1, REDIR, 0, 0, "d1_redir3");
      step(1, 0, NOP, 0, NO,    0, 0, "d1_counts");

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
